// File: rtl/ov7670_cfg_pkg.sv
// Shared types and table markers for the OV7670 register-configuration sequencer.
// The register table uses two reserved entries: end-of-table and a timed pause.
package ov7670_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_HOLD,
    PWR_WAIT,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_RESP,
    DELAY,
    DONE,
    ERROR
  } cfg_state_t;

  localparam logic [15:0] CFG_END   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY = 16'hFFF0;

  // Sizes the shared wait timer to the longest of the three waits.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter shared by every timed wait of the configuration sequencer.
// Loading N-1 on state entry keeps the owner in its waiting state for exactly N cycles.
module cfg_delay_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/ov7670_config_sequencer.sv
// OV7670 power-up and register configuration: camera reset timing, power-up wait,
// then streams {reg,value} pairs from a sync ROM to the SCCB master with NACK retries.
module ov7670_config_sequencer
  import ov7670_cfg_pkg::*;
#(
  parameter int ROM_DEPTH           = 76,
  parameter int ROM_ADDR_WIDTH      = $clog2(ROM_DEPTH),
  parameter int RESET_HOLD_CYCLES   = 100_000,
  parameter int POWERUP_WAIT_CYCLES = 1_000_000,
  parameter int DELAY_CYCLES        = 1_000_000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  output logic                      reset_cmos_o,
  output logic                      power_mode_cmos_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [15:0]               rom_data_i,
  output logic                      sccb_req_o,
  output logic [7:0]                sccb_reg_o,
  output logic [7:0]                sccb_data_o,
  input  logic                      sccb_ready_i,
  input  logic                      sccb_done_i,
  input  logic                      sccb_nack_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [ROM_ADDR_WIDTH-1:0] write_count_o
);

  localparam int TIMER_WIDTH =
    $clog2(max3(RESET_HOLD_CYCLES, POWERUP_WAIT_CYCLES, DELAY_CYCLES) + 1);
  localparam int RETRY_WIDTH = $clog2(MAX_RETRIES + 1);

  localparam logic [TIMER_WIDTH-1:0]    HOLD_LOAD  = TIMER_WIDTH'(RESET_HOLD_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0]    PWR_LOAD   = TIMER_WIDTH'(POWERUP_WAIT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0]    DELAY_LOAD = TIMER_WIDTH'(DELAY_CYCLES - 1);
  localparam logic [ROM_ADDR_WIDTH-1:0] LAST_ADDR  = ROM_ADDR_WIDTH'(ROM_DEPTH - 1);
  localparam logic [RETRY_WIDTH-1:0]    LAST_RETRY = RETRY_WIDTH'(MAX_RETRIES - 1);

  cfg_state_t                state_reg, state_next;
  logic [ROM_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ROM_ADDR_WIDTH-1:0] count_reg, count_next;
  logic [RETRY_WIDTH-1:0]    retry_reg, retry_next;
  logic [7:0]                reg_reg, reg_next;
  logic [7:0]                data_reg, data_next;
  logic                      reset_cmos_reg, reset_cmos_next;

  logic                      timer_load;
  logic [TIMER_WIDTH-1:0]    timer_value;
  logic                      timer_expired;

  cfg_delay_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk     (clk_i),
    .rst     (reset_i),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      count_reg      <= '0;
      retry_reg      <= '0;
      reg_reg        <= '0;
      data_reg       <= '0;
      reset_cmos_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      count_reg      <= count_next;
      retry_reg      <= retry_next;
      reg_reg        <= reg_next;
      data_reg       <= data_next;
      reset_cmos_reg <= reset_cmos_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    count_next      = count_reg;
    retry_next      = retry_reg;
    reg_next        = reg_reg;
    data_next       = data_reg;
    reset_cmos_next = reset_cmos_reg;
    timer_load      = 1'b0;
    timer_value     = '0;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_next      = RST_HOLD;
          addr_next       = '0;
          count_next      = '0;
          retry_next      = '0;
          reset_cmos_next = 1'b0;
          timer_load      = 1'b1;
          timer_value     = HOLD_LOAD;
        end
      end

      RST_HOLD: begin
        if (timer_expired) begin
          state_next      = PWR_WAIT;
          reset_cmos_next = 1'b1;
          timer_load      = 1'b1;
          timer_value     = PWR_LOAD;
        end
      end

      PWR_WAIT: begin
        if (timer_expired) begin
          state_next = FETCH;
        end
      end

      FETCH: state_next = DECODE;

      DECODE: begin
        if (rom_data_i == CFG_END) begin
          state_next = DONE;
        end else if (rom_data_i == CFG_DELAY) begin
          state_next  = DELAY;
          timer_load  = 1'b1;
          timer_value = DELAY_LOAD;
        end else begin
          state_next = ISSUE;
          reg_next   = rom_data_i[15:8];
          data_next  = rom_data_i[7:0];
        end
      end

      ISSUE: begin
        if (sccb_ready_i) begin
          state_next = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        if (sccb_done_i) begin
          if (!sccb_nack_i) begin
            count_next = count_reg + ROM_ADDR_WIDTH'(1);
            retry_next = '0;
            // The table ends at its last entry even without an end marker.
            if (addr_reg == LAST_ADDR) begin
              state_next = DONE;
            end else begin
              addr_next  = addr_reg + ROM_ADDR_WIDTH'(1);
              state_next = FETCH;
            end
          end else begin
            retry_next = retry_reg + RETRY_WIDTH'(1);
            state_next = (retry_reg == LAST_RETRY) ? ERROR : ISSUE;
          end
        end
      end

      DELAY: begin
        if (timer_expired) begin
          if (addr_reg == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            addr_next  = addr_reg + ROM_ADDR_WIDTH'(1);
            state_next = FETCH;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // The camera is never put into power-down; only RESET# is sequenced.
  assign power_mode_cmos_o = 1'b0;
  assign reset_cmos_o      = reset_cmos_reg;
  assign rom_addr_o        = addr_reg;
  assign sccb_req_o        = (state_reg == ISSUE);
  assign sccb_reg_o        = reg_reg;
  assign sccb_data_o       = data_reg;
  assign busy_o            = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERROR);
  assign done_o            = (state_reg == DONE);
  assign error_o           = (state_reg == ERROR);
  assign write_count_o     = count_reg;

endmodule
